// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types, default widths and counter sizing for ram_ctrl
package ram_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  // One extra bit over the largest phase length keeps every CYC-1 load in range.
  function automatic int cnt_width(input int setup_cyc, input int wen_cyc,
                                   input int hold_cyc, input int read_cyc);
    int m;
    m = setup_cyc;
    if (wen_cyc > m)  m = wen_cyc;
    if (hold_cyc > m) m = hold_cyc;
    if (read_cyc > m) m = read_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// rtl/ram_ctrl_if.sv - request/response channel of ram_ctrl
// RAM_CTRL_AUTOINC_EN adds the req_inc_i request field.
interface ram_ctrl_if import ram_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
`ifdef RAM_CTRL_AUTOINC_EN
  logic              req_inc_i;
`endif
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
`ifdef RAM_CTRL_AUTOINC_EN
    output req_inc_i,
`endif
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
`ifdef RAM_CTRL_AUTOINC_EN
    input  req_inc_i,
`endif
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

endinterface

// File: rtl/ram_ctrl_timer.sv
// rtl/ram_ctrl_timer.sv - loadable down-counter shared by all ram_ctrl wait states
module ram_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - request/response front-end sequencing a 1K x 8 asynchronous RAM
// RAM_CTRL_AUTOINC_EN adds an auto-incrementing address pointer.
module ram_ctrl import ram_ctrl_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int SETUP_CYC = 1,
  parameter int WEN_CYC   = 2,
  parameter int HOLD_CYC  = 1,
  parameter int READ_CYC  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ram_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wen_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              busy_o
);

  localparam int CNT_W = cnt_width(SETUP_CYC, WEN_CYC, HOLD_CYC, READ_CYC);

  state_e            state_q, state_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;
  logic [ADDR_W-1:0] used_addr;

  assign accept = bus.req_valid_i && (state_q == ST_IDLE);

`ifdef RAM_CTRL_AUTOINC_EN
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  assign used_addr = bus.req_inc_i ? ptr_q : bus.req_addr_i;
  assign ptr_d     = accept ? used_addr + ADDR_W'(1) : ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign used_addr = bus.req_addr_i;
`endif

  ram_ctrl_timer #(.W(CNT_W)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .zero_o  (tmr_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ram_wen_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ram_wen_q   <= ram_wen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          if (bus.req_we_i) begin
            state_d = ST_SETUP;
            tmr_val = CNT_W'(SETUP_CYC - 1);
          end else begin
            state_d = ST_RD_WAIT;
            tmr_val = CNT_W'(READ_CYC - 1);
          end
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(WEN_CYC - 1);
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC - 1);
        end
      end
      ST_HOLD:    if (tmr_zero) state_d = ST_IDLE;
      ST_RD_WAIT: if (tmr_zero) state_d = ST_RESP;
      ST_RESP:    if (bus.rsp_ready_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // WEn is decoded from the next state so the pin itself comes straight off a flop.
  always_comb begin
    ram_wen_d   = (state_d == ST_STROBE);
    addr_d      = accept ? used_addr : addr_q;
    data_d      = accept ? bus.req_wdata_i : data_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    if ((state_q == ST_RD_WAIT) && tmr_zero) begin
      rsp_valid_d = 1'b1;
      rdata_d     = ram_data_i;
    end else if ((state_q == ST_RESP) && bus.rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign bus.req_ready_o = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign ram_wen_o       = ram_wen_q;
  assign ram_addr_o      = addr_q;
  assign ram_data_o      = data_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - self-checking bench for ram_ctrl with a behavioural RAM and reference memory
// RAM_CTRL_AUTOINC_EN enables the pointer sequence and random req_inc_i.
module tb_ram_ctrl;

  localparam int S = 1;
  localparam int W = 2;
  localparam int H = 1;
  localparam int R = 2;
`ifdef RAM_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    int         rsp_wait;
    logic       junk;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [9:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wen;
  logic [7:0] ram_rdata;
  logic       busy;

  logic [7:0] ram_mem [1024];
  logic [7:0] ref_mem [1024];
  logic [9:0] ref_ptr;
  int         total;
  int         bad;

  ram_ctrl_if #(.DATA_W(8), .ADDR_W(10)) rif ();

  ram_ctrl #(
    .DATA_W(8), .ADDR_W(10), .SETUP_CYC(S), .WEN_CYC(W), .HOLD_CYC(H), .READ_CYC(R)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (rif),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_data),
    .ram_wen_o  (ram_wen),
    .ram_data_i (ram_rdata),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wen) ram_mem[ram_addr] <= ram_data;
  assign ram_rdata = ram_mem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [9:0] addr, input logic [7:0] wdata,
                           input logic inc);
    rif.req_valid_i = 1'b1;
    rif.req_we_i    = we;
    rif.req_addr_i  = addr;
    rif.req_wdata_i = wdata;
`ifdef RAM_CTRL_AUTOINC_EN
    rif.req_inc_i   = inc;
`endif
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!rif.req_ready_o && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("req_ready_wait", rif.req_ready_o, 1'b1);
  endtask

  // One full transaction with per-cycle timing checks against the phase lengths.
  task automatic txn(input logic we, input logic [9:0] addr, input logic [7:0] wdata,
                     input logic inc, input int rsp_wait, input logic junk,
                     output logic [7:0] got);
    logic [9:0] used;
    int         lim;
    logic       exp_v;
    used = addr;
    if (AUTOINC && inc) used = ref_ptr;
    got = '0;
    @(negedge clk);
    rif.rsp_ready_i = 1'b0;
    drive_req(we, addr, wdata, inc);
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    rif.req_valid_i = 1'b0;
    ref_ptr = used + 10'd1;
    if (we) begin
      lim = S + W + H;
      for (int k = 0; k <= lim; k++) begin
        check("wr_wen", ram_wen, (k >= S) && (k < S + W));
        check("wr_req_ready", rif.req_ready_o, k == lim);
        check("wr_busy", busy, k != lim);
        check("wr_addr", ram_addr, used);
        check("wr_data", ram_data, wdata);
        if (k < lim) @(negedge clk);
      end
      ref_mem[used] = wdata;
    end else begin
      lim = R + rsp_wait + 1;
      for (int k = 0; k <= lim; k++) begin
        exp_v = (k >= R) && (k <= R + rsp_wait);
        check("rd_rsp_valid", rif.rsp_valid_o, exp_v);
        check("rd_req_ready", rif.req_ready_o, k == lim);
        check("rd_busy", busy, k != lim);
        check("rd_addr", ram_addr, used);
        if (exp_v) begin
          check("rd_rdata", rif.rsp_rdata_o, ref_mem[used]);
          got = rif.rsp_rdata_o;
        end
        if (k == R + rsp_wait) begin
          rif.rsp_ready_i = 1'b1;
          rif.req_valid_i = 1'b0;
        end else if (junk && k < R + rsp_wait) begin
          drive_req(1'b1, ~used, 8'hE7, 1'b0);
        end
        if (k < lim) @(negedge clk);
      end
      rif.rsp_ready_i = 1'b0;
      rif.req_valid_i = 1'b0;
    end
  endtask

  vec_t       vecs [8];
  logic [7:0] got;
  int         c;
  int         pick;
  logic       r_we;
  logic [9:0] r_addr;
  logic       r_inc;

  initial begin
    vecs[0] = '{1'b1, 10'd100, 8'd9,    0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 10'd100, 8'd0,    0, 1'b0, 8'd9};
    vecs[2] = '{1'b0, 10'd100, 8'd0,    5, 1'b1, 8'd9};
    vecs[3] = '{1'b1, 10'd0,   8'hAA,   0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 10'd0,   8'd0,    1, 1'b0, 8'hAA};
    vecs[5] = '{1'b1, 10'd512, 8'h5A,   0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 10'd512, 8'd0,    2, 1'b1, 8'h5A};
    vecs[7] = '{1'b0, 10'd100, 8'd0,    0, 1'b0, 8'd9};

    total = 0;
    bad   = 0;
    ref_ptr = '0;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    clk = 1'b0;
    rst = 1'b0;
    rif.req_valid_i = 1'b0;
    rif.req_we_i    = 1'b0;
    rif.req_addr_i  = '0;
    rif.req_wdata_i = '0;
    rif.rsp_ready_i = 1'b0;
`ifdef RAM_CTRL_AUTOINC_EN
    rif.req_inc_i   = 1'b0;
`endif
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wen", ram_wen, 1'b0);
    check("rst_addr", ram_addr, 10'd0);
    check("rst_data", ram_data, 8'd0);
    check("rst_rsp_valid", rif.rsp_valid_o, 1'b0);
    check("rst_rdata", rif.rsp_rdata_o, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", rif.req_ready_o, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, vecs[i].rsp_wait, vecs[i].junk, got);
      if (!vecs[i].we) check("table_rdata", got, vecs[i].exp_rdata);
    end

    // Back-to-back: read held on the bus while the write is still sequencing.
    @(negedge clk);
    drive_req(1'b1, 10'd1023, 8'h55, 1'b0);
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 10'd1023, 8'h00, 1'b0);
    rif.rsp_ready_i = 1'b1;
    c = 0;
    while (!rif.req_ready_o && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("b2b_ready_cycle", c, S + W + H);
    @(posedge clk);
    @(negedge clk);
    rif.req_valid_i = 1'b0;
    c = 0;
    while (!rif.rsp_valid_o && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("b2b_rsp_latency", c, R);
    check("b2b_rdata", rif.rsp_rdata_o, 8'h55);
    @(negedge clk);
    check("b2b_rsp_drop", rif.rsp_valid_o, 1'b0);
    check("b2b_req_ready", rif.req_ready_o, 1'b1);
    rif.rsp_ready_i = 1'b0;
    ref_mem[1023] = 8'h55;
    ref_ptr = '0;

    // Reset while WEn is high must drop it before the next edge.
    @(negedge clk);
    drive_req(1'b1, 10'd200, 8'h33, 1'b0);
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    rif.req_valid_i = 1'b0;
    repeat (S) @(negedge clk);
    check("mid_wen_before", ram_wen, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_wen", ram_wen, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", rif.req_ready_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = '0;
    txn(1'b1, 10'd200, 8'h44, 1'b0, 0, 1'b0, got);
    txn(1'b0, 10'd200, 8'h00, 1'b0, 0, 1'b0, got);
    check("mid_readback", got, 8'h44);

`ifdef RAM_CTRL_AUTOINC_EN
    txn(1'b1, 10'd1023, 8'h11, 1'b0, 0, 1'b0, got);
    txn(1'b1, 10'd700,  8'h22, 1'b1, 0, 1'b0, got);
    txn(1'b1, 10'd701,  8'h33, 1'b1, 0, 1'b0, got);
    txn(1'b0, 10'd0, 8'h00, 1'b0, 0, 1'b0, got);
    check("inc_addr0", got, 8'h22);
    txn(1'b0, 10'd1, 8'h00, 1'b0, 0, 1'b0, got);
    check("inc_addr1", got, 8'h33);
`endif

    for (int i = 0; i < 40; i++) begin
      pick   = $urandom_range(0, 7);
      r_addr = (pick == 7) ? 10'd1023 : 10'(pick * 128);
      r_we   = 1'($urandom_range(0, 1));
      r_inc  = AUTOINC ? 1'($urandom_range(0, 1)) : 1'b0;
      txn(r_we, r_addr, 8'($urandom), r_inc, $urandom_range(0, 3),
          1'($urandom_range(0, 1)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
